// File: rtl/ext_bus_fifo_pkg.sv
// Shared constants for the buffered stream-to-external-bus adapter:
// register map, STATUS/CTRL bit positions and FSM encodings.
package ext_bus_pkg;

  localparam int ADDR_DATA   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_CTRL   = 2;
  localparam int ADDR_THRESH = 3;

  localparam int STAT_EMPTY_BIT   = 16;
  localparam int STAT_FULL_BIT    = 17;
  localparam int STAT_TIMEOUT_BIT = 18;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_ACK       = 2'd2
  } state_e;

endpackage

// File: rtl/ext_bus_fifo_if.sv
// Stream input plus external-bus request/response signals of the adapter.
// The bridge/stream source uses the master view, the adapter the slave view.
interface ext_bus_fifo_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] stream;
  logic                  stream_valid;
  logic                  stream_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  bus_enable;
  logic                  r_wbar;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_BYTES-1:0] byte_enable;
  logic                  ack;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  irq;

  modport master (
    output stream, stream_valid, addr, bus_enable, r_wbar, write_data, byte_enable,
    input  stream_ready, ack, read_data, irq
  );

  modport slave (
    input  stream, stream_valid, addr, bus_enable, r_wbar, write_data, byte_enable,
    output stream_ready, ack, read_data, irq
  );

endinterface

// File: rtl/ext_bus_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == PTR_W'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  // Flush discards a push arriving in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push)            wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i && !empty_o)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ext_bus_fifo.sv
// Register-mapped FIFO adapter: queues the feature stream and lets the bus
// bridge drain it through DATA/STATUS/CTRL/THRESH words with a level irq.
//
// state        | meaning
// ST_IDLE      | waiting for bus_enable, decodes and performs the access
// ST_WAIT_DATA | DATA read on empty FIFO, waiting for a word or timeout
// ST_ACK       | one-cycle ack with latched read_data
module ext_bus_fifo
  import ext_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input logic           clk,
  input logic           rst,
  ext_bus_fifo_if.slave bus
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic                  irq_en_q, irq_en_d;
  logic [LEVEL_W-1:0]    thresh_q, thresh_d;
  logic                  to_flag_q, to_flag_d;
  logic                  irq_q;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  unused_bus_bits;

  assign unused_bus_bits = ^{bus.byte_enable, bus.write_data};

  assign bus.stream_ready = ctrl_en_q && !fifo_full;
  assign fifo_push        = bus.stream_valid && bus.stream_ready;
  assign bus.ack          = (state_q == ST_ACK);
  assign bus.read_data    = (state_q == ST_ACK) ? rdata_q : '0;
  assign bus.irq          = irq_q;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_i  (bus.stream),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ctrl_en_d  = ctrl_en_q;
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    to_flag_d  = to_flag_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.bus_enable) begin
          if (bus.r_wbar && bus.addr == ADDR_WIDTH'(ADDR_DATA)) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              rdata_d  = fifo_head;
              state_d  = ST_ACK;
            end else begin
              cnt_d   = '0;
              state_d = ST_WAIT_DATA;
            end
          end else begin
            rdata_d = '0;
            state_d = ST_ACK;
            if (bus.r_wbar) begin
              case (bus.addr)
                ADDR_WIDTH'(ADDR_STATUS): begin
                  rdata_d[LEVEL_W-1:0]     = fifo_level;
                  rdata_d[STAT_EMPTY_BIT]   = fifo_empty;
                  rdata_d[STAT_FULL_BIT]    = fifo_full;
                  rdata_d[STAT_TIMEOUT_BIT] = to_flag_q;
                end
                ADDR_WIDTH'(ADDR_CTRL): begin
                  rdata_d[CTRL_EN_BIT]     = ctrl_en_q;
                  rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
                end
                ADDR_WIDTH'(ADDR_THRESH): rdata_d[LEVEL_W-1:0] = thresh_q;
                default: ;
              endcase
            end else begin
              case (bus.addr)
                ADDR_WIDTH'(ADDR_STATUS):
                  if (bus.write_data[STAT_TIMEOUT_BIT]) to_flag_d = 1'b0;
                ADDR_WIDTH'(ADDR_CTRL): begin
                  ctrl_en_d  = bus.write_data[CTRL_EN_BIT];
                  irq_en_d   = bus.write_data[CTRL_IRQ_EN_BIT];
                  fifo_flush = bus.write_data[CTRL_FLUSH_BIT];
                end
                ADDR_WIDTH'(ADDR_THRESH): thresh_d = bus.write_data[LEVEL_W-1:0];
                default: ;
              endcase
            end
          end
        end
      end
      ST_WAIT_DATA: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rdata_d  = fifo_head;
          state_d  = ST_ACK;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          rdata_d   = '0;
          to_flag_d = 1'b1;
          state_d   = ST_ACK;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ctrl_en_q <= 1'b1;
      irq_en_q  <= 1'b0;
      thresh_q  <= '0;
      to_flag_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ctrl_en_q <= ctrl_en_d;
      irq_en_q  <= irq_en_d;
      thresh_q  <= thresh_d;
      to_flag_q <= to_flag_d;
      irq_q     <= irq_en_q && !fifo_empty && (fifo_level >= thresh_q);
    end
  end

endmodule

// File: tb/tb_ext_bus_fifo.sv
// Scoreboard bench for ext_bus_fifo: a queue-based reference model predicts
// every bus response; a negedge monitor pops and compares on each ack.
module tb_ext_bus_fifo;
  import ext_bus_pkg::*;

  localparam int DW      = 128;
  localparam int AW      = 5;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 255;
  localparam int LW      = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] data;
    bit            chk;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ext_bus_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ext_bus_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  sb_t exp_q[$];

  logic [DW-1:0] model_q[$];
  bit            m_en  = 1'b1;
  bit            m_ien = 1'b0;
  bit            m_to  = 1'b0;
  int            m_thr = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit m_irq();
    return m_ien && (model_q.size() > 0) && (model_q.size() >= m_thr);
  endfunction

  function automatic logic [DW-1:0] status_word();
    logic [DW-1:0] w = '0;
    w[LW-1:0] = LW'(model_q.size());
    w[16]     = (model_q.size() == 0);
    w[17]     = (model_q.size() == DEPTH);
    w[18]     = m_to;
    return w;
  endfunction

  // Monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1'b1, 1'b0);
        end else begin
          sb_t e;
          e = exp_q.pop_front();
          if (e.chk) check("read_data", bus.read_data, e.data);
        end
      end else if (bus.read_data !== '0) begin
        check("read_data_idle", bus.read_data, '0);
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic bus_xfer(input bit rd, input int a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp, input bit chk_data, output int lat);
    sb_t e;
    e.data = exp;
    e.chk  = chk_data;
    exp_q.push_back(e);
    bus.addr        = AW'(a);
    bus.r_wbar      = rd;
    bus.write_data  = wd;
    bus.byte_enable = 16'($urandom());
    bus.bus_enable  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.ack && lat < TIMEOUT + 10);
    bus.bus_enable = 1'b0;
    check("ack_seen", bus.ack, 1'b1);
    if (!bus.ack && exp_q.size() > 0) void'(exp_q.pop_back());
    @(posedge clk); #1;
    check("ack_one_cycle", bus.ack, 1'b0);
  endtask

  task automatic reg_read(input int a);
    logic [DW-1:0] exp = '0;
    int lat;
    case (a)
      ADDR_STATUS: exp = status_word();
      ADDR_CTRL:   begin exp[0] = m_en; exp[2] = m_ien; end
      ADDR_THRESH: exp[LW-1:0] = LW'(m_thr);
      default:     exp = '0;
    endcase
    bus_xfer(1'b1, a, rnd_word(), exp, 1'b1, lat);
    check("reg_read_latency", lat, 1);
  endtask

  task automatic reg_write(input int a, input logic [DW-1:0] wd);
    int lat;
    bus_xfer(1'b0, a, wd, '0, 1'b0, lat);
    check("reg_write_latency", lat, 1);
    case (a)
      ADDR_STATUS: if (wd[18]) m_to = 1'b0;
      ADDR_CTRL: begin
        if (wd[1]) model_q.delete();
        m_en  = wd[0];
        m_ien = wd[2];
      end
      ADDR_THRESH: m_thr = int'(wd[LW-1:0]);
      default: ;
    endcase
  endtask

  task automatic data_read();
    logic [DW-1:0] exp;
    int exp_lat, lat;
    if (model_q.size() > 0) begin
      exp     = model_q.pop_front();
      exp_lat = 1;
    end else begin
      exp     = '0;
      exp_lat = TIMEOUT + 1;
      m_to    = 1'b1;
    end
    bus_xfer(1'b1, ADDR_DATA, '0, exp, 1'b1, lat);
    check("data_read_latency", lat, exp_lat);
  endtask

  task automatic stream_cycles(input int n, input bit rand_valid);
    for (int i = 0; i < n; i++) begin
      bit v, rdy;
      v   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy = m_en && (model_q.size() < DEPTH);
      bus.stream       = rnd_word();
      bus.stream_valid = v;
      check("stream_ready", bus.stream_ready, rdy);
      if (v && rdy) model_q.push_back(bus.stream);
      @(posedge clk); #1;
    end
    bus.stream_valid = 1'b0;
  endtask

  task automatic settle_irq();
    @(posedge clk); #1;
    check("irq", bus.irq, m_irq());
  endtask

  task automatic reset_model();
    model_q.delete();
    m_en  = 1'b1;
    m_ien = 1'b0;
    m_to  = 1'b0;
    m_thr = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w, v;
    int lat;
    rst              = 1'b1;
    bus.stream       = '0;
    bus.stream_valid = 1'b0;
    bus.addr         = '0;
    bus.bus_enable   = 1'b0;
    bus.r_wbar       = 1'b1;
    bus.write_data   = '0;
    bus.byte_enable  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_ack", bus.ack, 1'b0);
    check("rst_read_data", bus.read_data, '0);
    check("rst_irq", bus.irq, 1'b0);
    check("rst_stream_ready", bus.stream_ready, 1'b1);
    reg_read(ADDR_STATUS);
    reg_read(ADDR_CTRL);
    reg_read(ADDR_THRESH);

    // Three words in, three DATA reads out in order
    stream_cycles(3, 1'b0);
    repeat (3) data_read();
    reg_read(ADDR_STATUS);

    // Fill past full, then drain across the pointer wrap
    stream_cycles(20, 1'b0);
    reg_read(ADDR_STATUS);
    repeat (DEPTH) data_read();
    reg_read(ADDR_STATUS);

    // DATA read on empty, word arrives while waiting
    w = rnd_word();
    fork
      bus_xfer(1'b1, ADDR_DATA, '0, w, 1'b1, lat);
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.stream       = w;
        bus.stream_valid = 1'b1;
        check("wait_push_ready", bus.stream_ready, 1'b1);
        @(posedge clk); #1;
        bus.stream_valid = 1'b0;
      end
    join
    check("wait_data_latency_6_or_7", (lat == 6 || lat == 7), 1'b1);
    reg_read(ADDR_STATUS);

    // DATA read with nothing arriving times out, flag is W1C
    data_read();
    reg_read(ADDR_STATUS);
    v = '0; v[18] = 1'b1;
    reg_write(ADDR_STATUS, v);
    reg_read(ADDR_STATUS);

    // Level interrupt
    reg_write(ADDR_THRESH, DW'(4));
    reg_write(ADDR_CTRL, DW'(5));
    stream_cycles(4, 1'b0);
    check("irq_before_register", bus.irq, 1'b0);
    settle_irq();
    check("irq_raised", bus.irq, 1'b1);
    data_read();
    check("irq_fall", bus.irq, 1'b0);
    check("irq_model", bus.irq, m_irq());
    repeat (3) data_read();
    reg_write(ADDR_CTRL, DW'(1));

    // Flush racing a push: flush wins, ctrl_en stays set
    stream_cycles(8, 1'b0);
    fork
      reg_write(ADDR_CTRL, DW'(3));
      begin
        bus.stream       = rnd_word();
        bus.stream_valid = 1'b1;
        check("flush_push_ready", bus.stream_ready, 1'b1);
        @(posedge clk); #1;
        bus.stream_valid = 1'b0;
      end
    join
    reg_read(ADDR_STATUS);
    reg_read(ADDR_CTRL);

    // Reset during WAIT_DATA
    bus.addr       = AW'(ADDR_DATA);
    bus.r_wbar     = 1'b1;
    bus.bus_enable = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("wait_no_ack", bus.ack, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("midrst_ack", bus.ack, 1'b0);
    check("midrst_read_data", bus.read_data, '0);
    check("midrst_irq", bus.irq, 1'b0);
    bus.bus_enable = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    reset_model();
    @(posedge clk); #1;
    reg_read(ADDR_CTRL);
    reg_read(ADDR_STATUS);

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      int op, a;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: stream_cycles($urandom_range(1, 5), 1'b1);
        3, 4: begin
          if (model_q.size() > 0) data_read();
          else reg_read(ADDR_STATUS);
        end
        5: reg_read(ADDR_STATUS);
        6: begin
          v = '0;
          v[0] = ($urandom_range(0, 3) != 0);
          v[1] = ($urandom_range(0, 7) == 0);
          v[2] = 1'($urandom_range(0, 1));
          reg_write(ADDR_CTRL, v);
        end
        7: begin
          v = rnd_word();
          v[LW-1:0] = LW'($urandom_range(0, DEPTH + 2));
          reg_write(ADDR_THRESH, v);
        end
        8: reg_read(($urandom_range(0, 1) != 0) ? ADDR_CTRL : ADDR_THRESH);
        default: begin
          a = $urandom_range(4, (1 << AW) - 1);
          if ($urandom_range(0, 2) == 0) reg_write(ADDR_DATA, rnd_word());
          else if ($urandom_range(0, 1) != 0) reg_read(a);
          else reg_write(a, rnd_word());
        end
      endcase
      settle_irq();
    end

    while (model_q.size() > 0) data_read();
    reg_read(ADDR_STATUS);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
